// File: rtl/ahbl_arbiter_pkg.sv
// Shared AHB-Lite definitions for the splitter and arbiter.
// Transfer-type encodings and the address-phase control bundle.
package ahbl_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef struct packed {
        logic       hwrite;
        logic [1:0] htrans;
        logic [2:0] hsize;
        logic [2:0] hburst;
        logic [3:0] hprot;
        logic       hmastlock;
    } ahbl_ctrl_t;

    localparam int W_CTRL = $bits(ahbl_ctrl_t);

endpackage

// File: rtl/ahbl_arbiter_onehot_mux.sv
// AND-OR multiplexer driven by a one-hot (or all-zero) select.
// An all-zero select yields an all-zero output.
module ahbl_arbiter_onehot_mux #(
    parameter int N = 2,
    parameter int W = 32
) (
    input  logic [N*W-1:0] din,
    input  logic [N-1:0]   sel,
    output logic [W-1:0]   dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            dout = dout | (din[i*W +: W] & {W{sel[i]}});
        end
    end

endmodule

// File: rtl/ahbl_arbiter.sv
// N-to-1 AHB-Lite arbiter with fixed priority (lowest index wins).
// Losing requests are held in a per-port buffer and replayed later.
module ahbl_arbiter
    import ahbl_arbiter_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [N_PORTS-1:0]        src_hready,
    output logic [N_PORTS-1:0]        src_hready_resp,
    output logic [N_PORTS-1:0]        src_hresp,
    input  logic [N_PORTS*W_ADDR-1:0] src_haddr,
    input  logic [N_PORTS-1:0]        src_hwrite,
    input  logic [N_PORTS*2-1:0]      src_htrans,
    input  logic [N_PORTS*3-1:0]      src_hsize,
    input  logic [N_PORTS*3-1:0]      src_hburst,
    input  logic [N_PORTS*4-1:0]      src_hprot,
    input  logic [N_PORTS-1:0]        src_hmastlock,
    input  logic [N_PORTS*W_DATA-1:0] src_hwdata,
    output logic [N_PORTS*W_DATA-1:0] src_hrdata,

    output logic              dst_hready,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata
);

    localparam int W_B = W_ADDR + W_CTRL;

    logic [N_PORTS-1:0]     fresh;
    logic [N_PORTS-1:0]     req_a;
    logic [N_PORTS-1:0]     mast_gnt_a;
    logic [N_PORTS-1:0]     mast_gnt_d;
    logic [N_PORTS-1:0]     buf_valid;
    logic [N_PORTS*W_B-1:0] live_b;
    logic [N_PORTS*W_B-1:0] buf_b;
    logic [N_PORTS*W_B-1:0] src_b;
    logic [W_B-1:0]         sel_b;
    ahbl_ctrl_t             sel_ctrl;

    always_comb begin
        fresh  = '0;
        live_b = '0;
        src_b  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            fresh[i] = src_htrans[2*i+1] && src_hready[i];
            live_b[i*W_B +: W_B] = {
                src_haddr[i*W_ADDR +: W_ADDR],
                src_hwrite[i],
                src_htrans[i*2 +: 2],
                src_hsize[i*3 +: 3],
                src_hburst[i*3 +: 3],
                src_hprot[i*4 +: 4],
                src_hmastlock[i]
            };
            src_b[i*W_B +: W_B] = buf_valid[i] ?
                buf_b[i*W_B +: W_B] : live_b[i*W_B +: W_B];
        end
    end

    // Isolate the lowest set request bit
    assign req_a      = fresh | buf_valid;
    assign mast_gnt_a = req_a & (~req_a + N_PORTS'(1));

    ahbl_arbiter_onehot_mux #(
        .N (N_PORTS),
        .W (W_B)
    ) u_addr_mux (
        .din  (src_b),
        .sel  (mast_gnt_a),
        .dout (sel_b)
    );

    ahbl_arbiter_onehot_mux #(
        .N (N_PORTS),
        .W (W_DATA)
    ) u_wdata_mux (
        .din  (src_hwdata),
        .sel  (mast_gnt_d),
        .dout (dst_hwdata)
    );

    assign sel_ctrl      = ahbl_ctrl_t'(sel_b[W_CTRL-1:0]);
    assign dst_haddr     = sel_b[W_B-1 -: W_ADDR];
    assign dst_hwrite    = sel_ctrl.hwrite;
    assign dst_htrans    = |mast_gnt_a ? sel_ctrl.htrans : HTRANS_IDLE;
    assign dst_hsize     = sel_ctrl.hsize;
    assign dst_hburst    = sel_ctrl.hburst;
    assign dst_hprot     = sel_ctrl.hprot;
    assign dst_hmastlock = sel_ctrl.hmastlock;
    assign dst_hready    = dst_hready_resp;

    // Responses depend only on registered data-phase state
    always_comb begin
        src_hready_resp = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            src_hready_resp[i] = mast_gnt_d[i] ? dst_hready_resp : !buf_valid[i];
        end
    end

    assign src_hresp  = mast_gnt_d & {N_PORTS{dst_hresp}};
    assign src_hrdata = {N_PORTS{dst_hrdata}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mast_gnt_d <= '0;
            buf_valid  <= '0;
            buf_b      <= '0;
        end else begin
            if (dst_hready_resp) begin
                mast_gnt_d <= mast_gnt_a;
            end
            for (int i = 0; i < N_PORTS; i++) begin
                if (buf_valid[i]) begin
                    if (mast_gnt_a[i] && dst_hready_resp) begin
                        buf_valid[i] <= 1'b0;
                    end
                end else if (fresh[i] && !(mast_gnt_a[i] && dst_hready_resp)) begin
                    buf_valid[i]         <= 1'b1;
                    buf_b[i*W_B +: W_B]  <= live_b[i*W_B +: W_B];
                end
            end
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_chk
        a_no_fresh_while_buffered: assert property (
            @(posedge clk) disable iff (!rst_n)
            !(fresh[g] && buf_valid[g])
        );
    end

endmodule

// File: doc/ahbl_arbiter.md
AHBL_ARBITER -- requirements
Module: ahbl_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of upstream masters.
REQ-002 SHALL have parameters W_ADDR, default 32, and W_DATA, default 32, taken from hazard3_config.vh.
REQ-003 SHALL have clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have per-master slave-side ports, concatenated with port i at bits [i*W +: W]:
- src_hready  in  N_PORTS  upstream HREADY
- src_hready_resp  out  N_PORTS
- src_hresp  out  N_PORTS
- src_haddr  in  N_PORTS*W_ADDR
- src_hwrite  in  N_PORTS
- src_htrans  in  N_PORTS*2
- src_hsize  in  N_PORTS*3
- src_hburst  in  N_PORTS*3
- src_hprot  in  N_PORTS*4
- src_hmastlock  in  N_PORTS
- src_hwdata  in  N_PORTS*W_DATA
- src_hrdata  out  N_PORTS*W_DATA
REQ-005 SHALL have downstream master-side ports:
- dst_hready  out  1
- dst_hready_resp  in  1
- dst_hresp  in  1
- dst_haddr  out  W_ADDR
- dst_hwrite  out  1
- dst_htrans  out  2
- dst_hsize  out  3
- dst_hburst  out  3
- dst_hprot  out  4
- dst_hmastlock  out  1
- dst_hwdata  out  W_DATA
- dst_hrdata  in  W_DATA

Function
REQ-006 Fresh request, port i: src_htrans[i][1] && src_hready[i]; pending request: buf_valid[i]; request_a[i] = fresh or pending.
REQ-007 Grant mast_gnt_a SHALL be one-hot or zero, fixed priority: lowest index wins; zero when no request_a.
REQ-008 Address-phase outputs SHALL come from granted port's buffer if buf_valid, else its live inputs; dst_htrans SHALL be IDLE when mast_gnt_a is zero.
REQ-009 On clk edge with dst_hready_resp=1: mast_gnt_d <= mast_gnt_a; else mast_gnt_d holds.
REQ-010 A fresh request not accepted this cycle (not granted, or dst_hready_resp=0) SHALL be captured into port buffer (haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock); buf_valid[i] <= 1.
REQ-011 buf_valid[i] SHALL clear on the edge where the buffered request is granted with dst_hready_resp=1.
REQ-012 Fresh request while buf_valid[i]=1 is illegal (master is stalled); assertion SHALL flag it.
REQ-013 src_hready_resp[i] = dst_hready_resp if mast_gnt_d[i]; else 0 if buf_valid[i]; else 1.
REQ-014 src_hresp[i] = mast_gnt_d[i] && dst_hresp; the two-cycle ERROR response SHALL reach the master unchanged.
REQ-015 dst_hwdata SHALL be muxed by mast_gnt_d; src_hrdata SHALL broadcast dst_hrdata to all ports.
REQ-016 dst_hready SHALL equal dst_hready_resp.
REQ-017 No combinational path from src_htrans to any src_hready_resp; responses SHALL use data-phase state only.
REQ-018 hmastlock SHALL pass through; lock does not hold arbitration.
REQ-019 Latency: granted fresh request reaches dst same cycle; a request losing arbitration costs at least one extra cycle per winning transfer.

Reset
REQ-020 rst_n low SHALL clear mast_gnt_d, all buf_valid and buffer contents to 0; dst_htrans=IDLE; src_hready_resp all 1; src_hresp all 0.
REQ-021 Reset mid-transfer SHALL drop all pending buffered requests without issuing them.

Structure
REQ-022 HTRANS_IDLE/BUSY/NONSEQ/SEQ constants SHALL live in a shared ahbl package/header used by the splitter and arbiter.
REQ-023 onehot_mux SHALL be reused for address-phase and hwdata muxing; priority select SHALL be inline.

Verification
REQ-024 Single master: port0 NONSEQ write 0x2000_0000, data 0xDEADBEEF -> dst sees the same cycle, src_hready_resp[0]=1, zero added latency.
REQ-025 Collision: ports 0 and 1 NONSEQ same cycle (0x100, 0x200) -> dst 0x100 then 0x200; port1 hready_resp low one cycle; buf_valid[1] set then cleared.
REQ-026 Slave wait states: dst_hready_resp low 3 cycles during port0 data phase while port1 requests -> port1 buffered, issued after wait ends, no lost/duplicated transfer.
REQ-027 Error: dst_hresp=1 two cycles for port1 read -> src_hresp[1]=1 with hready_resp 0 then 1; port0 responses unaffected.
REQ-028 Reset asserted with buf_valid[1]=1 -> after release dst_htrans=IDLE, all src_hready_resp=1, no stale transfer.
REQ-029 Random 10k-cycle traffic vs. reference-model scoreboard: per-master order preserved, every transfer completes exactly once.
